sprite_plotter: RTL
===================

SPRITE_PLOTTER -- requirements
Module: sprite_plotter

Interface
REQ-001 SHALL have parameter X_W, default 8, meaning pixel x-coordinate width.
REQ-002 SHALL have parameter Y_W, default 7, meaning pixel y-coordinate width.
REQ-003 SHALL have parameter COLOUR_W, default 3, meaning pixel colour width.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to draw one sprite, sampled in IDLE only.
REQ-007 SHALL have port sprite  input  25  5x5 bitmap; bit 24 = row 0 col 0, bit 0 = row 4 col 4, row-major.
REQ-008 SHALL have port erase  input  1  force all 25 pixels to bg_colour.
REQ-009 SHALL have port x_base  input  X_W  sprite top-left x.
REQ-010 SHALL have port y_base  input  Y_W  sprite top-left y.
REQ-011 SHALL have port fg_colour  input  COLOUR_W  colour for set bits.
REQ-012 SHALL have port bg_colour  input  COLOUR_W  colour for clear bits and erase.
REQ-013 SHALL have port x_out  output  X_W  pixel x to frame-buffer writer.
REQ-014 SHALL have port y_out  output  Y_W  pixel y to frame-buffer writer.
REQ-015 SHALL have port colour_out  output  COLOUR_W  pixel colour.
REQ-016 SHALL have port plot  output  1  write strobe; x_out/y_out/colour_out valid when high.
REQ-017 SHALL have port busy  output  1  high from accepted start through last pixel.
REQ-018 SHALL have port done  output  1  one-cycle pulse after last pixel.

Function
REQ-019 SHALL implement states IDLE, DRAW, DONE; IDLE->DRAW on start, DRAW->DONE after pixel (4,4), DONE->IDLE unconditionally.
REQ-020 SHALL latch sprite, erase, x_base, y_base, fg_colour, bg_colour on the edge accepting start; later input changes do not affect the sprite in progress.
REQ-021 SHALL ignore start in DRAW and DONE (no queuing).
REQ-022 SHALL scan row 0..4 outer, col 0..4 inner, one pixel per cycle, 25 cycles, using separate 3-bit row/col counters (no division).
REQ-023 SHALL register all outputs; start accepted at edge N gives first pixel on outputs after edge N+1, last pixel after N+25, done high for the cycle after edge N+26.
REQ-024 SHALL drive x_out = x_base + col and y_out = y_base + row, truncated modulo 2^X_W / 2^Y_W (wrap, no clipping).
REQ-025 SHALL drive colour_out = fg_colour when the latched bit is 1 and erase is 0, else bg_colour.
REQ-026 SHALL hold busy high for exactly 25 cycles per sprite; busy and done never high together.
REQ-027 SHALL accept start in the cycle done is low and state is IDLE, i.e. minimum 27 cycles between accepted starts.

Reset
REQ-028 SHALL on reset go to IDLE, clear counters, and drive plot=0, busy=0, done=0, x_out=0, y_out=0, colour_out=0.
REQ-029 SHALL let reset override start in the same cycle and abort a draw mid-sprite with no further plot or done.

Configuration
REQ-030 SHALL, with SPRITE_PLOTTER_TRANSPARENT_EN defined, hold plot low for clear bits when erase is 0 (counters still advance, timing unchanged); erase still plots all 25 pixels.
REQ-031 SHALL, without SPRITE_PLOTTER_TRANSPARENT_EN, assert plot on all 25 draw cycles.

Structure
REQ-032 SHALL take SPRITE_DIM=5, SPRITE_BITS=25 and the state encoding from shared package pac_pkg.
REQ-033 SHALL be a single module; no sub-module required.

Verification
REQ-034 Bench: sprite=0x0EFE3EE (right-mouth frame A), base (10,20), fg=3'b110, bg=0, start one cycle -> 25 plots, first (10,20,0), third (12,20,6), last (14,24,0), done at N+26.
REQ-035 Bench: erase=1, sprite=0x1FFFFFF, bg=3'b001 -> all 25 pixels colour 1.
REQ-036 Bench: base (254,126) -> pixel (4,4) at (2,2) via wrap.
REQ-037 Bench: start held high continuously -> sprites begin every 27 cycles, no overlap; input change during DRAW has no effect.
REQ-038 Bench: reset asserted at pixel 12 -> plot/busy low next cycle, no done, next start draws cleanly from (0,0).
REQ-039 Bench: TRANSPARENT_EN defined, sprite=0x1000001 -> exactly 2 plot pulses at pixel indices 0 and 24, done still at N+26.

Source files
------------

// File: rtl/pac_pkg.sv
// Shared sprite-plotter constants and FSM state encoding.
// The 5x5 sprite geometry lives here so the plotter and its users agree on it.
package pac_pkg;

    localparam int SPRITE_DIM  = 5;
    localparam int SPRITE_BITS = SPRITE_DIM * SPRITE_DIM;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sprite_plotter.sv
// Scans a latched 5x5 bitmap into one frame-buffer pixel write per cycle.
// Define SPRITE_PLOTTER_TRANSPARENT_EN to suppress writes for clear bits.
module sprite_plotter
    import pac_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SPRITE_BITS-1:0] sprite,
    input  logic                   erase,
    input  logic [X_W-1:0]         x_base,
    input  logic [Y_W-1:0]         y_base,
    input  logic [COLOUR_W-1:0]    fg_colour,
    input  logic [COLOUR_W-1:0]    bg_colour,
    output logic [X_W-1:0]         x_out,
    output logic [Y_W-1:0]         y_out,
    output logic [COLOUR_W-1:0]    colour_out,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    localparam logic [2:0] LAST = 3'(SPRITE_DIM - 1);

    state_t state, state_nxt;

    logic [SPRITE_BITS-1:0] bits_q;
    logic                   erase_q;
    logic [X_W-1:0]         x_q;
    logic [Y_W-1:0]         y_q;
    logic [COLOUR_W-1:0]    fg_q;
    logic [COLOUR_W-1:0]    bg_q;
    logic [2:0]             row;
    logic [2:0]             col;
    logic                   last_px;
    logic                   cur_bit;
    logic                   px_plot;

    assign last_px = (row == LAST) && (col == LAST);
    // The bitmap is shifted left each pixel, so the current bit is always the MSB
    assign cur_bit = bits_q[SPRITE_BITS-1];

`ifdef SPRITE_PLOTTER_TRANSPARENT_EN
    assign px_plot = erase_q | cur_bit;
`else
    assign px_plot = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = DRAW;
            DRAW:    if (last_px) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bits_q     <= '0;
            erase_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            fg_q       <= '0;
            bg_q       <= '0;
            row        <= '0;
            col        <= '0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            plot <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bits_q  <= sprite;
                        erase_q <= erase;
                        x_q     <= x_base;
                        y_q     <= y_base;
                        fg_q    <= fg_colour;
                        bg_q    <= bg_colour;
                        row     <= '0;
                        col     <= '0;
                    end
                end
                DRAW: begin
                    x_out      <= x_q + X_W'(col);
                    y_out      <= y_q + Y_W'(row);
                    colour_out <= (cur_bit && !erase_q) ? fg_q : bg_q;
                    plot       <= px_plot;
                    busy       <= 1'b1;
                    bits_q     <= {bits_q[SPRITE_BITS-2:0], 1'b0};
                    if (col == LAST) begin
                        col <= '0;
                        row <= row + 3'd1;
                    end else begin
                        col <= col + 3'd1;
                    end
                end
                DONE: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
